vga_fb_arbiter: RTL and testbench
=================================

Name: vga_fb_arbiter

Overview:
- Shares one single-port 320x240 framebuffer RAM between two requesters: the scanout line fetcher (high priority) and a pixel writer (drawing engine or CPU).
- On request, bursts one display line from RAM into the scanout line buffer, one word per cycle.
- Grants writer slots when no fetch is active, and at a bounded interval during a fetch.
- Sits between the VGA timing generator's line prefetch request and the framebuffer RAM.

Parameters:
- H_DISPLAY, 320, pixels per line and words per fetch burst.
- V_DISPLAY, 240, valid lines.
- ADDR_W, 17, RAM word address width.
- DATA_W, 12, pixel width (4:4:4 RGB).
- WR_SLOT_PERIOD, 16, consecutive fetch reads after which one pending write is serviced; 0 means no writes during a fetch.

Ports:
- clk  in  1  system/pixel clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- line_req  in  1  one-cycle pulse: fetch line line_y.
- line_y  in  8  line to fetch; sampled with line_req.
- line_busy  out  1  high from the cycle after line_req is accepted through the line_done cycle.
- line_done  out  1  one-cycle pulse when the fetch completes.
- line_overrun  out  1  sticky flag: line_req arrived while busy.
- ovr_clr  in  1  synchronous clear of line_overrun.
- lb_we  out  1  line buffer write enable.
- lb_addr  out  9  line buffer index, 0..H_DISPLAY-1.
- lb_data  out  DATA_W  pixel written to the line buffer.
- wr_req  in  1  level; held with stable payload until wr_ack.
- wr_x  in  9  write column.
- wr_y  in  8  write row.
- wr_data  in  DATA_W  write pixel.
- wr_ack  out  1  one-cycle pulse; write accepted (or dropped).
- wr_err  out  1  pulses with wr_ack when the coordinates are out of range.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data; valid 1 cycle after a read.

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; all outputs 0, including line_overrun; counters 0. Reset during a fetch abandons it; no line_done is issued.
- Address calculation: mem_addr = y*H_DISPLAY + x, truncated to ADDR_W.
- Registered outputs: a grant decided at edge N drives mem_*, wr_ack and wr_err during cycle N+1.
- States: IDLE, FETCH, FSLOT (write slot inside a fetch), FDRAIN (last read data return).
- IDLE transitions:
  - line_req with line_y < V_DISPLAY goes to FETCH, index = 0. line_req has priority over a simultaneous wr_req.
  - line_req with line_y >= V_DISPLAY: no RAM reads, no lb_we, line_done pulses the next cycle, line_busy stays low.
  - wr_req alone: one write cycle with mem_en=1, mem_we=1 and wr_ack=1.
- Write handling:
  - No re-grant is allowed in the cycle wr_ack is high, so writes are at most 1 every 2 cycles.
  - wr_x >= H_DISPLAY or wr_y >= V_DISPLAY: wr_ack and wr_err pulse, mem_en=0, nothing written.
- FETCH:
  - Each cycle: mem_en=1, mem_we=0, mem_addr = base+index, index++.
  - One cycle later: lb_we=1, lb_addr = that index, lb_data = mem_rdata.
- FSLOT:
  - Entry condition: WR_SLOT_PERIOD != 0, the consecutive-read count reaches WR_SLOT_PERIOD, wr_req is high, and wr_ack is not currently high.
  - Effect: one write cycle is inserted (rules as in IDLE, including wr_err), the read count clears, then the state returns to FETCH.
  - The lb_we for the preceding read still occurs during the slot cycle.
  - With no pending write, the read count saturates and the fetch continues.
- FDRAIN:
  - Entered after read index H_DISPLAY-1.
  - Final lb_we occurs here with line_done=1 in the same cycle; then back to IDLE.
- Fetch latency: with no slots inserted, line_done comes H_DISPLAY+1 cycles after the first read.
- line_req while line_busy: ignored and line_overrun set. Set has priority over a simultaneous ovr_clr.
- A line_req arriving in the cycle line_done is high is accepted (back-to-back fetches).

Test Plan:
- Reset mid-fetch (index 100): all outputs go 0 asynchronously; no line_done follows; line_overrun=0.
- line_req with line_y=5 and RAM preloaded with word=addr[11:0]: lb_addr 0..319 receive the words at 1600..1919; line_done pulses 321 cycles after the first read; exactly 320 lb_we pulses.
- wr_req (x=319, y=239, data=0xABC) held high: single wr_ack; mem_addr=76799 and mem_we=1 in the ack cycle; next grant no earlier than 2 cycles later.
- wr_req held high during a fetch with WR_SLOT_PERIOD=16: writes land after reads 16, 32, …; line buffer contents stay correct; line_done comes at 320 reads plus the inserted slots.
- Simultaneous line_req and wr_req in IDLE: fetch starts first; second line_req mid-fetch sets line_overrun; ovr_clr clears it.
- Out-of-range inputs: wr_x=320 gives wr_ack and wr_err with no mem_en; line_y=240 gives line_done the next cycle with no reads and no lb_we.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - framebuffer RAM arbiter between scanout line fetch and pixel writer
module vga_fb_arbiter #(
  parameter int H_DISPLAY      = 320,
  parameter int V_DISPLAY      = 240,
  parameter int ADDR_W         = 17,
  parameter int DATA_W         = 12,
  parameter int WR_SLOT_PERIOD = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              line_req,
  input  logic [7:0]        line_y,
  output logic              line_busy,
  output logic              line_done,
  output logic              line_overrun,
  input  logic              ovr_clr,
  output logic              lb_we,
  output logic [8:0]        lb_addr,
  output logic [DATA_W-1:0] lb_data,
  input  logic              wr_req,
  input  logic [8:0]        wr_x,
  input  logic [7:0]        wr_y,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(WR_SLOT_PERIOD + 2);
  localparam logic [8:0]       H_PIX  = 9'(H_DISPLAY);
  localparam logic [8:0]       H_LAST = 9'(H_DISPLAY - 1);
  localparam logic [7:0]       V_LIN  = 8'(V_DISPLAY);
  localparam logic [CNT_W-1:0] SLOT_N = CNT_W'(WR_SLOT_PERIOD);

  typedef enum logic [1:0] {IDLE, FETCH, FSLOT, FDRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [8:0]        idx;
  logic [CNT_W-1:0]  rd_cnt;

  logic              wr_ok;
  logic              rd_now;
  logic              slot_go;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] line_base;

  assign wr_ok     = (wr_x < H_PIX) && (wr_y < V_LIN);
  assign wr_addr   = ADDR_W'(wr_y) * ADDR_W'(H_DISPLAY) + ADDR_W'(wr_x);
  assign line_base = ADDR_W'(line_y) * ADDR_W'(H_DISPLAY);
  assign rd_now    = mem_en && !mem_we;
  assign slot_go   = (SLOT_N != '0) && (rd_cnt >= SLOT_N) && wr_req && !wr_ack;

  // Read data arrives combinationally one cycle after the registered read.
  assign lb_data = lb_we ? mem_rdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      base         <= '0;
      idx          <= '0;
      rd_cnt       <= '0;
      line_busy    <= 1'b0;
      line_done    <= 1'b0;
      line_overrun <= 1'b0;
      lb_we        <= 1'b0;
      lb_addr      <= '0;
      wr_ack       <= 1'b0;
      wr_err       <= 1'b0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      wr_ack    <= 1'b0;
      wr_err    <= 1'b0;
      line_done <= 1'b0;
      lb_we     <= rd_now;
      if (rd_now) begin
        lb_addr <= idx - 9'd1;
      end

      if (line_req && state != IDLE) begin
        line_overrun <= 1'b1;
      end else if (ovr_clr) begin
        line_overrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          line_busy <= 1'b0;
          if (line_req) begin
            if (line_y < V_LIN) begin
              // First read goes out with the grant so the burst starts immediately.
              state     <= FETCH;
              line_busy <= 1'b1;
              base      <= line_base;
              mem_en    <= 1'b1;
              mem_addr  <= line_base;
              idx       <= 9'd1;
              rd_cnt    <= (SLOT_N == '0) ? '0 : CNT_W'(1);
            end else begin
              line_done <= 1'b1;
            end
          end else if (wr_req && !wr_ack) begin
            mem_en    <= wr_ok;
            mem_we    <= wr_ok;
            mem_addr  <= wr_addr;
            mem_wdata <= wr_data;
            wr_ack    <= 1'b1;
            wr_err    <= !wr_ok;
          end
        end

        FETCH, FSLOT: begin
          if (state == FETCH && slot_go) begin
            mem_en    <= wr_ok;
            mem_we    <= wr_ok;
            mem_addr  <= wr_addr;
            mem_wdata <= wr_data;
            wr_ack    <= 1'b1;
            wr_err    <= !wr_ok;
            rd_cnt    <= '0;
            state     <= FSLOT;
          end else begin
            mem_en   <= 1'b1;
            mem_addr <= base + ADDR_W'(idx);
            idx      <= idx + 9'd1;
            if (rd_cnt < SLOT_N) begin
              rd_cnt <= rd_cnt + CNT_W'(1);
            end
            state <= (idx == H_LAST) ? FDRAIN : FETCH;
          end
        end

        FDRAIN: begin
          // Last read is on the bus; its line buffer write lands with line_done.
          line_done <= 1'b1;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - self-checking bench for vga_fb_arbiter
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        line_req = 1'b0;
  logic [7:0]  line_y = '0;
  logic        ovr_clr = 1'b0;
  logic        wr_req = 1'b0;
  logic [8:0]  wr_x = '0;
  logic [7:0]  wr_y = '0;
  logic [11:0] wr_data = '0;
  logic [11:0] mem_rdata = '0;
  logic        line_busy, line_done, line_overrun, lb_we, wr_ack, wr_err, mem_en, mem_we;
  logic [8:0]  lb_addr;
  logic [11:0] lb_data, mem_wdata;
  logic [16:0] mem_addr;

  vga_fb_arbiter #(
    .H_DISPLAY(320), .V_DISPLAY(240), .ADDR_W(17), .DATA_W(12), .WR_SLOT_PERIOD(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .line_req(line_req), .line_y(line_y),
    .line_busy(line_busy), .line_done(line_done), .line_overrun(line_overrun),
    .ovr_clr(ovr_clr), .lb_we(lb_we), .lb_addr(lb_addr), .lb_data(lb_data),
    .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_err(wr_err), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: unwritten words read back as addr[11:0].
  logic [11:0] ram [0:76799];
  bit          ram_wr [0:76799];
  logic [11:0] lb_mem [0:319];

  always @(posedge clk) begin
    if (mem_en && mem_addr < 17'd76800) begin
      if (mem_we) begin
        ram[mem_addr]    <= mem_wdata;
        ram_wr[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : mem_addr[11:0];
      end
    end
  end

  always @(posedge clk) begin
    if (lb_we && lb_addr < 9'd320) lb_mem[lb_addr] <= lb_data;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {6'd0, mem_en, mem_we, mem_addr, mem_wdata, lb_we, lb_addr, lb_data,
            line_busy, line_done, line_overrun, wr_ack, wr_err};
  endfunction

  task automatic wait_done(input int budget, output int lat, output int reads, output int lbwes,
                           output int acks, output int first_rd, output logic [16:0] first_addr,
                           output bit slot_ok, output bit busy_ok);
    lat = 0; reads = 0; lbwes = 0; acks = 0; first_rd = 0; first_addr = '0;
    slot_ok = 1'b1; busy_ok = 1'b1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (!line_busy) busy_ok = 1'b0;
      if (mem_en && !mem_we) begin
        reads++;
        if (first_rd == 0) begin
          first_rd = i;
          first_addr = mem_addr;
        end
      end
      if (lb_we) lbwes++;
      if (wr_ack) begin
        acks++;
        if (reads != 16 * acks || !mem_we) slot_ok = 1'b0;
      end
      if (line_done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic pulse_line(input logic [7:0] y);
    @(negedge clk);
    line_y = y;
    line_req = 1'b1;
    @(posedge clk);
    #1 line_req = 1'b0;
  endtask

  function automatic int lb_bad(input int base);
    int bad = 0;
    for (int i = 0; i < 320; i++) begin
      if (int'(lb_mem[i]) != ((base + i) % 4096)) bad++;
    end
    return bad;
  endfunction

  typedef struct {
    logic [8:0]  x;
    logic [7:0]  y;
    logic [11:0] d;
    logic        err;
    logic [16:0] addr;
  } wvec_t;

  wvec_t       wv [7];
  int          lat, reads, lbwes, acks, first_rd, ack_at, n_done, n_en, n_lbwe, n_busy;
  logic [16:0] first_addr;
  bit          slot_ok, busy_ok, found;

  initial begin
    wv[0] = '{9'd319, 8'd239, 12'hABC, 1'b0, 17'd76799};
    wv[1] = '{9'd0,   8'd0,   12'h001, 1'b0, 17'd0};
    wv[2] = '{9'd5,   8'd7,   12'h5A5, 1'b0, 17'd2245};
    wv[3] = '{9'd100, 8'd200, 12'hF0F, 1'b0, 17'd64100};
    wv[4] = '{9'd320, 8'd0,   12'h111, 1'b1, 17'd0};
    wv[5] = '{9'd0,   8'd240, 12'h222, 1'b1, 17'd0};
    wv[6] = '{9'd511, 8'd255, 12'h333, 1'b1, 17'd0};

    repeat (2) @(negedge clk);
    chk("reset_outputs", all_outs(), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_outputs", all_outs(), 64'd0);

    // Writer requests from IDLE, one table vector at a time.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      wr_x = wv[i].x; wr_y = wv[i].y; wr_data = wv[i].d; wr_req = 1'b1;
      @(negedge clk);
      chk($sformatf("wr_ack[%0d]", i), wr_ack, 1);
      chk($sformatf("wr_err[%0d]", i), wr_err, wv[i].err);
      chk($sformatf("mem_en[%0d]", i), mem_en, !wv[i].err);
      chk($sformatf("mem_we[%0d]", i), mem_we, !wv[i].err);
      if (!wv[i].err) begin
        chk($sformatf("mem_addr[%0d]", i), mem_addr, wv[i].addr);
        chk($sformatf("mem_wdata[%0d]", i), mem_wdata, wv[i].d);
      end
      if (i == 0) begin
        @(negedge clk);
        chk("no_regrant_after_ack", wr_ack, 0);
        @(negedge clk);
        chk("regrant_two_cycles", wr_ack, 1);
      end
      wr_req = 1'b0;
      @(negedge clk);
      chk($sformatf("wr_ack_clear[%0d]", i), wr_ack, 0);
    end
    chk("ram_corner_word", ram[76799], 12'hABC);

    // Out-of-range line: immediate done, no reads.
    pulse_line(8'd240);
    @(negedge clk);
    chk("oor_line_done", line_done, 1);
    chk("oor_line_busy", line_busy, 0);
    chk("oor_mem_en", mem_en, 0);
    @(negedge clk);
    chk("oor_done_single", line_done, 0);
    chk("oor_no_read", {mem_en, lb_we}, 2'b00);

    // Plain fetch of line 5.
    pulse_line(8'd5);
    wait_done(600, lat, reads, lbwes, acks, first_rd, first_addr, slot_ok, busy_ok);
    chk("fetch_first_rd_cycle", first_rd, 1);
    chk("fetch_first_addr", first_addr, 17'd1600);
    chk("fetch_latency", lat, 321);
    chk("fetch_reads", reads, 320);
    chk("fetch_lb_we", lbwes, 320);
    chk("fetch_busy", busy_ok, 1);
    @(negedge clk);
    chk("fetch_busy_clear", line_busy, 0);
    chk("lb_line5", lb_bad(1600), 0);

    // Fetch line 20 with a writer continuously pending.
    pulse_line(8'd20);
    wr_x = 9'd7; wr_y = 8'd10; wr_data = 12'h3C3; wr_req = 1'b1;
    wait_done(600, lat, reads, lbwes, acks, first_rd, first_addr, slot_ok, busy_ok);
    wr_req = 1'b0;
    chk("slot_latency", lat, 340);
    chk("slot_reads", reads, 320);
    chk("slot_lb_we", lbwes, 320);
    chk("slot_acks", acks, 19);
    chk("slot_positions", slot_ok, 1);
    @(negedge clk);
    chk("slot_ram_word", ram[3207], 12'h3C3);
    chk("lb_line20", lb_bad(6400), 0);

    // Simultaneous line_req and wr_req, then overrun handling.
    @(negedge clk);
    line_y = 8'd5; line_req = 1'b1;
    wr_x = 9'd3; wr_y = 8'd10; wr_data = 12'h123; wr_req = 1'b1;
    @(posedge clk);
    #1 line_req = 1'b0;
    @(negedge clk);
    chk("prio_fetch_first", {mem_en, mem_we, wr_ack}, 3'b100);
    chk("prio_fetch_addr", mem_addr, 17'd1600);
    ack_at = 0;
    for (int n = 2; n <= 40; n++) begin
      @(negedge clk);
      if (wr_ack) begin
        ack_at = n;
        break;
      end
    end
    chk("prio_slot_cycle", ack_at, 17);
    chk("prio_slot_write", {mem_we, mem_addr}, {1'b1, 17'd3203});
    wr_req = 1'b0;
    repeat (5) @(negedge clk);
    pulse_line(8'd9);
    @(negedge clk);
    chk("overrun_set", line_overrun, 1);
    chk("overrun_busy", line_busy, 1);
    @(negedge clk);
    line_req = 1'b1; ovr_clr = 1'b1;
    @(posedge clk);
    #1 line_req = 1'b0; ovr_clr = 1'b0;
    @(negedge clk);
    chk("overrun_set_priority", line_overrun, 1);
    ovr_clr = 1'b1;
    @(posedge clk);
    #1 ovr_clr = 1'b0;
    @(negedge clk);
    chk("overrun_cleared", line_overrun, 0);
    wait_done(600, lat, reads, lbwes, acks, first_rd, first_addr, slot_ok, busy_ok);
    chk("overrun_fetch_done", lat != 0, 1);
    @(negedge clk);
    chk("overrun_req_ignored", {line_busy, mem_en}, 2'b00);

    // Reset in the middle of a fetch.
    pulse_line(8'd5);
    repeat (10) @(negedge clk);
    pulse_line(8'd9);
    found = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (mem_en && !mem_we && mem_addr == 17'd1700) begin
        found = 1'b1;
        break;
      end
    end
    chk("rst_reached_idx100", found, 1);
    chk("rst_overrun_before", line_overrun, 1);
    #2 reset_n = 1'b0;
    #1 chk("rst_async_outputs", all_outs(), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    n_done = 0; n_en = 0; n_lbwe = 0; n_busy = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (line_done) n_done++;
      if (mem_en) n_en++;
      if (lb_we) n_lbwe++;
      if (line_busy) n_busy++;
    end
    chk("rst_no_done", n_done, 0);
    chk("rst_no_mem", n_en, 0);
    chk("rst_no_lb_we", n_lbwe, 0);
    chk("rst_no_busy", n_busy, 0);
    chk("rst_overrun_after", line_overrun, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
